// File: rtl/logic_op_pkg.sv
// Shared types and the bitwise function table for logic_op_pipe.
// apply_op works at MAX_W bits; callers truncate to their own WIDTH.
package logic_op_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  function automatic logic [MAX_W-1:0] apply_op(input op_e op,
                                                input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] r;
    r = a & b;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NAND:   r = ~(a & b);
      OP_NOR:    r = ~(a | b);
      OP_XNOR:   r = ~(a ^ b);
      OP_PASS_A: r = a;
      OP_NOT_A:  r = ~a;
      default:   r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_skid.sv
// 2-entry valid/ready FIFO. head_q always drives the output, so the
// presented payload only changes on a pop or when the FIFO was empty.
module logic_op_skid #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [PW-1:0] push_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data,
  output logic [1:0]    count
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop;
  logic          push_ok;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign count     = cnt_q;
  assign pop       = out_valid && out_ready;
  assign push_ok   = push && ((cnt_q < 2'd2) || pop);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push_ok, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_data;
        else               tail_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the new entry lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Registered bitwise logic unit with AND-accumulate bursts and a 2-entry
// output buffer. Define LOGIC_OP_PARITY_EN to add the out_par port.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_zero,
  output logic             out_ones
`ifdef LOGIC_OP_PARITY_EN
  ,
  output logic             out_par
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ones;
`ifdef LOGIC_OP_PARITY_EN
    logic             par;
`endif
  } ent_t;

  localparam int PW = $bits(ent_t);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] push_val;
  logic             push;
  logic             accept;
  ent_t             push_ent, out_ent;
  logic [PW-1:0]    out_raw;
  logic [1:0]       count;

  // run_q holds in_ready low through reset and goes high on the first edge after.
  assign run_d    = 1'b1;
  assign in_ready = run_q && (count < 2'd2);
  assign accept   = in_valid && in_ready;

  always_comb begin
    r = WIDTH'(apply_op(op_e'(op), MAX_W'(a), MAX_W'(b)));
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    push     = 1'b0;
    push_val = r;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!acc_mode || in_last) begin
            push     = 1'b1;
            push_val = r;
          end else begin
            acc_d   = r;
            state_d = ACC;
          end
        end
        ACC: begin
          if (in_last) begin
            push     = 1'b1;
            push_val = acc_q & r;
            state_d  = IDLE;
          end else begin
            acc_d = acc_q & r;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    push_ent      = '0;
    push_ent.y    = push_val;
    push_ent.zero = (push_val == '0);
    push_ent.ones = &push_val;
`ifdef LOGIC_OP_PARITY_EN
    push_ent.par  = ^push_val;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      run_q   <= run_d;
    end
  end

  logic_op_skid #(.PW(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_ent),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_raw),
    .count     (count)
  );

  assign out_ent  = ent_t'(out_raw);
  assign y        = out_ent.y;
  assign out_zero = out_ent.zero;
  assign out_ones = out_ent.ones;
`ifdef LOGIC_OP_PARITY_EN
  assign out_par  = out_ent.par;
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe: op table, accumulate burst, backpressure,
// flags, reset mid-burst, and parity when LOGIC_OP_PARITY_EN is defined.
module tb_logic_op_pipe;
  import logic_op_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       acc_mode, in_last;
  logic       out_valid, out_ready;
  logic [7:0] y;
  logic       out_zero, out_ones;
`ifdef LOGIC_OP_PARITY_EN
  logic       out_par;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_mode  (acc_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .out_zero  (out_zero),
    .out_ones  (out_ones)
`ifdef LOGIC_OP_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] ta, input logic [7:0] tb,
                       input logic [2:0] top, input logic tacc, input logic tlast);
    in_valid = v;
    a        = ta;
    b        = tb;
    op       = top;
    acc_mode = tacc;
    in_last  = tlast;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp1 [8];
    logic [7:0] acc_a [4];
    exp1  = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hF0, 8'h0F};
    acc_a = '{8'hFF, 8'hF7, 8'h7F, 8'hFE};

    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(0, 8'h00, 8'h00, 3'd0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_ones", out_ones, 0);
`ifdef LOGIC_OP_PARITY_EN
    chk("rst_par", out_par, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);

    // Test 1: all eight ops, one per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'hF0, 8'h3C, i[2:0], 0, 0);
      @(negedge clk);
      chk("t1_valid", out_valid, 1);
      chk("t1_y", y, exp1[i]);
      chk("t1_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;

    // Test 2: 4-beat AND accumulate of PASS_A
    for (int i = 0; i < 4; i++) begin
      drive(1, acc_a[i], 8'h00, OP_PASS_A, (i == 0), (i == 3));
      @(negedge clk);
      if (i < 3) begin
        chk("t2_no_out", out_valid, 0);
      end else begin
        chk("t2_valid", out_valid, 1);
        chk("t2_y", y, 8'h76);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_single", out_valid, 0);

    // Test 3: backpressure with three beats
    out_ready = 1'b0;
    drive(1, 8'h01, 8'h02, OP_OR, 0, 0);
    @(negedge clk);
    chk("t3_v0", out_valid, 1);
    chk("t3_y0", y, 8'h03);
    chk("t3_rdy1", in_ready, 1);
    drive(1, 8'h0F, 8'hFF, OP_XOR, 0, 0);
    @(negedge clk);
    chk("t3_full", in_ready, 0);
    chk("t3_hold_a", y, 8'h03);
    drive(1, 8'hAA, 8'h0F, OP_AND, 0, 0);
    @(negedge clk);
    chk("t3_still_full", in_ready, 0);
    chk("t3_hold_b", y, 8'h03);
    chk("t3_hold_v", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_y1", y, 8'hF0);
    chk("t3_v1", out_valid, 1);
    chk("t3_rdy_back", in_ready, 1);
    @(negedge clk);
    chk("t3_y2", y, 8'h0A);
    chk("t3_v2", out_valid, 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_drained", out_valid, 0);

    // Test 4: flags
    drive(1, 8'h0F, 8'hF0, OP_AND, 0, 0);
    @(negedge clk);
    chk("t4_y_and", y, 8'h00);
    chk("t4_zero", out_zero, 1);
    chk("t4_ones_n", out_ones, 0);
    drive(1, 8'h5A, 8'h5A, OP_XNOR, 0, 0);
    @(negedge clk);
    chk("t4_y_xnor", y, 8'hFF);
    chk("t4_ones", out_ones, 1);
    chk("t4_zero_n", out_zero, 0);
    in_valid = 1'b0;
    @(negedge clk);

    // Test 5: reset in the middle of a burst, with a result still buffered
    out_ready = 1'b0;
    drive(1, 8'h11, 8'h22, OP_OR, 0, 0);
    @(negedge clk);
    chk("t5_buffered", out_valid, 1);
    drive(1, 8'hFF, 8'h00, OP_PASS_A, 1, 0);
    @(negedge clk);
    drive(1, 8'hF0, 8'h00, OP_PASS_A, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_y", y, 0);
    chk("t5_rst_rdy", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rdy", in_ready, 1);
    out_ready = 1'b1;
    drive(1, 8'h01, 8'h02, OP_OR, 0, 0);
    @(negedge clk);
    chk("t5_valid", out_valid, 1);
    chk("t5_y", y, 8'h03);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_drained", out_valid, 0);

`ifdef LOGIC_OP_PARITY_EN
    // Test 6: parity
    drive(1, 8'h07, 8'h00, OP_XOR, 0, 0);
    @(negedge clk);
    chk("t6_y", y, 8'h07);
    chk("t6_par", out_par, 1);
    drive(1, 8'h03, 8'h00, OP_XOR, 0, 0);
    @(negedge clk);
    chk("t6_y_even", y, 8'h03);
    chk("t6_par_even", out_par, 0);
    in_valid = 1'b0;
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
